conv_scan_ctrl: RTL and testbench

CONV_SCAN_CTRL -- requirements
Module: conv_scan_ctrl

---
 rtl/conv_scan_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_conv_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_scan_ctrl.sv
// -----------------------------------------------------------------------------
// conv_scan_ctrl
//
// Raster-scan controller for a 3x3 convolution pipeline. For each frame it
// issues one 3-row column read per cycle, walking bands top to bottom and
// columns left to right. It also tracks, through a LAT-deep tag pipeline,
// which pixel-unit results are complete 3x3 windows and what their
// coordinates are.
//
// Parameters
//   XB   width of column coordinates and of the image width
//   YB   width of row coordinates and of the image height
//   LAT  cycles from a column issue to its pixel-unit result (1..15)
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      one-cycle frame request, only looked at in IDLE
//   img_w_i      frame width, captured together with start_i
//   img_h_i      frame height, captured together with start_i
//   mem_rd_en_o  a column read is issued this cycle
//   mem_x_o      column address of the read
//   mem_y_o      top row of the 3-row band being read
//   pix_valid_o  pixel-unit output is a valid 3x3 result this cycle
//   pix_x_o      window top-left column of the valid result (0 otherwise)
//   pix_y_o      window top-left row of the valid result (0 otherwise)
//   busy_o       frame in progress (SCAN or DRAIN)
//   proc_done_o  one-cycle pulse when the frame has fully drained
//   err_o        one-cycle pulse after a start with a frame smaller than 3x3
//   dbg_state_o  current FSM state (0 IDLE, 1 SCAN, 2 DRAIN)
//
// Handshake: start_i is a single-cycle request with no ready; it is accepted
// only when the FSM is in IDLE on that rising edge and is silently dropped
// in any other state. err_o and proc_done_o are single-cycle pulses with no
// acknowledge.
// -----------------------------------------------------------------------------
module conv_scan_ctrl #(
  parameter int XB  = 10,
  parameter int YB  = 10,
  parameter int LAT = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [XB-1:0] img_w_i,
  input  logic [YB-1:0] img_h_i,
  output logic          mem_rd_en_o,
  output logic [XB-1:0] mem_x_o,
  output logic [YB-1:0] mem_y_o,
  output logic          pix_valid_o,
  output logic [XB-1:0] pix_x_o,
  output logic [YB-1:0] pix_y_o,
  output logic          busy_o,
  output logic          proc_done_o,
  output logic          err_o,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [XB-1:0] w_q, w_d;
  logic [YB-1:0] h_q, h_d;
  logic [XB-1:0] x_q, x_d;
  logic [YB-1:0] y_q, y_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Tag pipeline: one entry per cycle of pixel-unit latency.
  logic [LAT-1:0] tvld_q;
  logic [XB-1:0]  tx_q [LAT];
  logic [YB-1:0]  ty_q [LAT];

  logic          tag_vld;
  logic [XB-1:0] tag_x;
  logic [YB-1:0] tag_y;
  logic          last_col;
  logic          last_band;
  logic          size_ok;

  assign size_ok   = (img_w_i >= XB'(3)) && (img_h_i >= YB'(3));
  assign last_col  = (x_q == w_q - XB'(1));
  assign last_band = (y_q == h_q - YB'(3));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (size_ok) begin
            w_d     = img_w_i;
            h_d     = img_h_i;
            x_d     = '0;
            y_d     = '0;
            state_d = S_SCAN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_SCAN: begin
        if (last_col) begin
          x_d = '0;
          if (last_band) begin
            // Final column of the final band was issued this cycle.
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            y_d = y_q + YB'(1);
          end
        end else begin
          x_d = x_q + XB'(1);
        end
      end

      S_DRAIN: begin
        // LAT drain cycles: the last tagged issue surfaces in the final one,
        // so proc_done lands in the cycle right after the last pix_valid.
        if (cnt_q == 4'(LAT - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline. The first two columns of every band only prime the window,
  // so only columns x>=2 carry a tag; the window's left edge is x-2.
  // Untagged slots carry zero coordinates so pix_x/pix_y read 0 when idle.
  // ---------------------------------------------------------------------------
  assign tag_vld = (state_q == S_SCAN) && (x_q >= XB'(2));
  assign tag_x   = tag_vld ? (x_q - XB'(2)) : '0;
  assign tag_y   = tag_vld ? y_q : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tvld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tx_q[i] <= '0;
        ty_q[i] <= '0;
      end
    end else begin
      tvld_q[0] <= tag_vld;
      tx_q[0]   <= tag_x;
      ty_q[0]   <= tag_y;
      for (int i = 1; i < LAT; i++) begin
        tvld_q[i] <= tvld_q[i-1];
        tx_q[i]   <= tx_q[i-1];
        ty_q[i]   <= ty_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all are decoded from registered state only. Read coordinates are
  // forced to 0 outside SCAN so the bus is quiet between frames.
  // ---------------------------------------------------------------------------
  assign mem_rd_en_o = (state_q == S_SCAN);
  assign mem_x_o     = (state_q == S_SCAN) ? x_q : '0;
  assign mem_y_o     = (state_q == S_SCAN) ? y_q : '0;
  assign pix_valid_o = tvld_q[LAT-1];
  assign pix_x_o     = tx_q[LAT-1];
  assign pix_y_o     = ty_q[LAT-1];
  assign busy_o      = (state_q != S_IDLE);
  assign proc_done_o = done_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_conv_scan_ctrl.sv
module tb_conv_scan_ctrl;
  localparam int XB   = 10;
  localparam int YB   = 10;
  localparam int LAT  = 6;
  localparam int MAXC = 30000;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [XB-1:0] img_w;
  logic [YB-1:0] img_h;
  logic          mem_rd_en;
  logic [XB-1:0] mem_x;
  logic [YB-1:0] mem_y;
  logic          pix_valid;
  logic [XB-1:0] pix_x;
  logic [YB-1:0] pix_y;
  logic          busy;
  logic          proc_done;
  logic          err;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  conv_scan_ctrl #(.XB(XB), .YB(YB), .LAT(LAT)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .img_w_i    (img_w),
    .img_h_i    (img_h),
    .mem_rd_en_o(mem_rd_en),
    .mem_x_o    (mem_x),
    .mem_y_o    (mem_y),
    .pix_valid_o(pix_valid),
    .pix_x_o    (pix_x),
    .pix_y_o    (pix_y),
    .busy_o     (busy),
    .proc_done_o(proc_done),
    .err_o      (err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- reference model ----------------
  // Expected outputs per cycle, filled in whenever the model accepts a frame.
  typedef struct packed {
    logic          rd;
    logic [XB-1:0] mx;
    logic [YB-1:0] my;
    logic          pv;
    logic [XB-1:0] px;
    logic [YB-1:0] py;
    logic          busy;
    logic          done;
    logic          err;
  } obs_t;

  obs_t exp_a [MAXC];
  int   cyc;
  int   free_at;   // first cycle in which a start is accepted again
  int   n_tests;
  int   n_fail;
  int   cnt_pv;

  function automatic obs_t actual();
    obs_t o;
    o.rd   = mem_rd_en;
    o.mx   = mem_x;
    o.my   = mem_y;
    o.pv   = pix_valid;
    o.px   = pix_x;
    o.py   = pix_y;
    o.busy = busy;
    o.done = proc_done;
    o.err  = err;
    return o;
  endfunction

  // A frame accepted at cycle s: issue k goes out in cycle s+1+k at
  // column k mod w of band k / w; columns >= 2 yield a window LAT cycles later.
  function automatic void add_frame(int s, int w, int h);
    int n;
    n = w * (h - 2);
    for (int k = 0; k < n; k++) begin
      int c, x, y;
      c = s + 1 + k;
      x = k % w;
      y = k / w;
      if (c < MAXC) begin
        exp_a[c].rd = 1'b1;
        exp_a[c].mx = XB'(x);
        exp_a[c].my = YB'(y);
      end
      if (x >= 2 && c + LAT < MAXC) begin
        exp_a[c+LAT].pv = 1'b1;
        exp_a[c+LAT].px = XB'(x - 2);
        exp_a[c+LAT].py = YB'(y);
      end
    end
    for (int c = s + 1; c <= s + n + LAT; c++)
      if (c < MAXC) exp_a[c].busy = 1'b1;
    if (s + n + LAT + 1 < MAXC) exp_a[s+n+LAT+1].done = 1'b1;
    free_at = s + n + LAT + 1;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_obs(input string name, input obs_t e);
    obs_t a;
    a = actual();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got rd=%0b x=%0d y=%0d pv=%0b px=%0d py=%0d busy=%0b done=%0b err=%0b, exp rd=%0b x=%0d y=%0d pv=%0b px=%0d py=%0d busy=%0b done=%0b err=%0b",
               name, cyc, a.rd, a.mx, a.my, a.pv, a.px, a.py, a.busy, a.done, a.err,
               e.rd, e.mx, e.my, e.pv, e.px, e.py, e.busy, e.done, e.err);
    end
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, exp %0d", name, got, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to the next cycle's midpoint and compare every output.
  task automatic next_cycle();
    @(negedge clk);
    cyc++;
    check_obs("outputs", (cyc < MAXC) ? exp_a[cyc] : obs_t'('0));
    if (pix_valid) cnt_pv++;
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic request(input int w, input int h);
    img_w = XB'(w);
    img_h = YB'(h);
    start = 1'b1;
    if (cyc >= free_at) begin
      if (w >= 3 && h >= 3) add_frame(cyc, w, h);
      else if (cyc + 1 < MAXC) exp_a[cyc+1].err = 1'b1;
    end
    next_cycle();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < free_at) next_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_obs("async_reset", obs_t'('0));
    for (int c = cyc + 1; c < MAXC; c++) exp_a[c] = '0;
    free_at = cyc + 1;
    next_cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int w;
    int h;
    int issues;    // mem_rd_en cycles
    int valids;    // pix_valid cycles
    int done_off;  // proc_done cycle relative to the start cycle, 0 = none
  } vec_t;

  vec_t tbl [8];

  initial begin
    int p0;
    for (int c = 0; c < MAXC; c++) exp_a[c] = '0;
    n_tests = 0;
    n_fail  = 0;
    cnt_pv  = 0;
    start   = 1'b0;
    img_w   = '0;
    img_h   = '0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    cyc = 0;
    check_obs("reset_state", obs_t'('0));
    rst_n   = 1'b1;
    free_at = 0;

    tbl[0] = '{w: 3,  h: 3, issues: 3,  valids: 1,  done_off: 10};
    tbl[1] = '{w: 5,  h: 4, issues: 10, valids: 6,  done_off: 17};
    tbl[2] = '{w: 4,  h: 3, issues: 4,  valids: 2,  done_off: 11};
    tbl[3] = '{w: 3,  h: 5, issues: 9,  valids: 3,  done_off: 16};
    tbl[4] = '{w: 6,  h: 6, issues: 24, valids: 16, done_off: 31};
    tbl[5] = '{w: 2,  h: 8, issues: 0,  valids: 0,  done_off: 0};
    tbl[6] = '{w: 8,  h: 2, issues: 0,  valids: 0,  done_off: 0};
    tbl[7] = '{w: 10, h: 3, issues: 10, valids: 8,  done_off: 17};

    foreach (tbl[i]) begin
      int c0, nr, nv, dc, nerr, budget;
      c0 = cyc;
      nr = 0; nv = 0; dc = 0; nerr = 0;
      budget = tbl[i].issues + LAT + 6;
      request(tbl[i].w, tbl[i].h);
      for (int k = 0; k < budget; k++) begin
        if (mem_rd_en) nr++;
        if (pix_valid) nv++;
        if (err) nerr++;
        if (proc_done) begin
          dc = cyc - c0;
          break;
        end
        next_cycle();
      end
      check_int($sformatf("tbl%0d_issues", i), nr, tbl[i].issues);
      check_int($sformatf("tbl%0d_valids", i), nv, tbl[i].valids);
      check_int($sformatf("tbl%0d_done", i), dc, tbl[i].done_off);
      check_int($sformatf("tbl%0d_err", i), nerr, (tbl[i].issues == 0) ? 1 : 0);
      idle(2);
    end

    // Second start and changed dimensions while scanning are ignored.
    p0 = cnt_pv;
    request(8, 5);
    idle(3);
    request(3, 3);
    img_w = XB'(20);
    img_h = YB'(1);
    idle(2);
    wait_idle();
    check_int("ignored_start_valids", cnt_pv - p0, 18);
    idle(2);

    // Reset in the middle of a scan, then a clean 3x3 frame.
    request(8, 8);
    idle(10);
    do_reset();
    p0 = cnt_pv;
    request(3, 3);
    wait_idle();
    idle(3);
    check_int("post_reset_valids", cnt_pv - p0, 1);

    // Start presented in the proc_done cycle gives back-to-back frames.
    request(4, 4);
    wait_idle();
    check_int("b2b_done_seen", int'(proc_done), 1);
    request(3, 3);
    check_int("b2b_first_issue", int'(mem_rd_en), 1);
    wait_idle();
    idle(2);

    // Randomized frames, stray starts, dimension wiggles and resets.
    for (int it = 0; it < 40; it++) begin
      int w, h, gap;
      if ($urandom_range(0, 4) != 0) begin
        w = $urandom_range(3, 12);
        h = $urandom_range(3, 8);
      end else begin
        w = $urandom_range(0, 4);
        h = $urandom_range(0, 3);
      end
      request(w, h);
      gap = $urandom_range(0, 60);
      for (int k = 0; k < gap; k++) begin
        if ($urandom_range(0, 7) == 0) request($urandom_range(0, 9), $urandom_range(0, 9));
        else begin
          img_w = XB'($urandom_range(0, 1023));
          next_cycle();
        end
      end
      if ($urandom_range(0, 14) == 0) do_reset();
    end
    wait_idle();
    idle(LAT + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
